pcie_status_led_ctrl: RTL and testbench
=======================================

// Module: pcie_status_led_ctrl
// PURPOSE
//  Downstream consumer of the PCIe/PS subsystem status nets (MMCM lock, interconnect and peripheral resets).
//  Drives the 3 board LEDs from one state machine: lock indicator, reset-release indicator, heartbeat.
//  Latches sticky fault on MMCM lock loss after bring-up; counts lock-loss events for software/ILA.
//  Runs entirely in pcie_clk_125MHz domain; async status inputs resynchronised locally.
// PARAMETERS
//  CNT_W              28   heartbeat counter width; LED[2] = cnt[CNT_W-1] (~0.47 Hz at 125 MHz)
//  FAST_BIT           23   counter bit used for fault blink on LED[0] (~7.5 Hz at 125 MHz); FAST_BIT < CNT_W
//  LOCK_STABLE_CYCLES 1024 consecutive synced-lock-high cycles required before lock counts as stable; >= 1
//  LOSS_W             4    width of saturating lock-loss counter
// PORTS
//  pcie_clk_125MHz      in  1       clock
//  sys_rst              in  1       synchronous active-high reset
//  pcie_mmcm_locked     in  1       MMCM lock, asynchronous
//  interconnect_aresetn in  1       AXI interconnect reset, active-low, asynchronous
//  peripheral_aresetn   in  1       AXI peripheral reset, active-low, asynchronous
//  clear_fault          in  1       single-cycle pulse, synchronous; acknowledges FAULT
//  EXT_LEDS             out 3       [0] lock, [1] resets released, [2] heartbeat
//  state_o              out 2       current FSM state encoding
//  fault                out 1       high while in FAULT
//  lock_loss_cnt        out LOSS_W  saturating count of lock-loss events
// BEHAVIOUR
//  - Clock pcie_clk_125MHz only; reset sys_rst synchronous, active-high, overrides all else.
//  - Reset values: EXT_LEDS=3'b000, state_o=WAIT_LOCK(2'd0), fault=0, lock_loss_cnt=0, heartbeat cnt=0,
//    stable counter=0, all synchroniser flops=0 (reads as unlocked / in reset).
//  - Each async input passes a 2-FF synchroniser; lk_s, rst_ok_s = synced interconnect & peripheral aresetn.
//  - Stable counter: lk_s=0 clears it; else increments, saturates at LOCK_STABLE_CYCLES; lock_stable=(cnt==max).
//  - Heartbeat counter: free-running CNT_W bits, wraps all-ones -> 0, never stops outside reset.
//  - FSM (encodings 0..3): WAIT_LOCK, WAIT_RST, RUN, FAULT.
//    WAIT_LOCK -> WAIT_RST when lock_stable.
//    WAIT_RST  -> RUN when lock_stable & rst_ok_s; -> WAIT_LOCK if lk_s=0 (no fault; bring-up not done).
//    RUN       -> FAULT if lk_s=0 (priority); else -> WAIT_RST if rst_ok_s=0.
//    FAULT     -> WAIT_LOCK when clear_fault=1 & lock_stable; clear_fault while unstable ignored (stay).
//  - lock_loss_cnt increments by 1 on every RUN->FAULT transition; saturates at 2^LOSS_W-1; cleared only by sys_rst.
//  - Outputs registered (1 cycle after state update). Input edge -> LED change: 2 sync + 1 FSM + 1 out = 4 cycles
//    (lock rise adds LOCK_STABLE_CYCLES).
//  - LED[0]: WAIT_LOCK 0; WAIT_RST/RUN 1; FAULT = cnt[FAST_BIT].
//  - LED[1]: 1 only in RUN.
//  - LED[2]: cnt[CNT_W-1] in every state (proves clock alive even in FAULT).
//  - Simultaneous lock loss and reset assertion in RUN: FAULT wins, counter increments once.
//  - Lock glitch shorter than sync window that never reaches lk_s: no effect by design.
//  - sys_rst mid-FAULT: returns to WAIT_LOCK, fault and loss count cleared.
// STRUCTURE
//  - Package pcie_status_pkg: state typedef/encodings (WAIT_LOCK=0, WAIT_RST=1, RUN=2, FAULT=3),
//    LED index constants LED_LOCK=0, LED_RST=1, LED_HB=2.
//  - One sub-module: sync_2ff (1-bit, synchronous reset to 0), instantiated 3x.
//  - Top holds counters, FSM and output registers; no other hierarchy.
// TESTING (bench params CNT_W=8, FAST_BIT=2, LOCK_STABLE_CYCLES=4, LOSS_W=2)
//  1 Reset then locked=1, both aresetn=1 -> WAIT_RST after 2+4 cycles, RUN next; EXT_LEDS[1:0]=2'b11 one cycle later.
//  2 Heartbeat: after reset, EXT_LEDS[2] toggles every 128 cycles; cnt wraps 255->0 without glitch.
//  3 In RUN drop locked -> FAULT within 3 cycles, fault=1, lock_loss_cnt=1, LED[0] toggles every 4 cycles.
//  4 In FAULT pulse clear_fault with locked=0 -> stays FAULT; restore lock, wait 4, pulse -> WAIT_LOCK, fault=0.
//  5 Four RUN->FAULT cycles -> lock_loss_cnt saturates at 3; same cycle lock loss + aresetn low -> FAULT, +1 only.
//  6 In RUN deassert peripheral_aresetn -> WAIT_RST, LED[1]=0, no fault; assert sys_rst in FAULT -> all outputs zero next cycle.

Source files
------------

// File: rtl/pcie_status_led_ctrl_pkg.sv
// pcie_status_pkg
//   Shared types and constants for the PCIe status LED controller.
//   - state_e   : controller FSM states and their fixed 2-bit encodings
//   - LED_*     : bit positions of the three board LEDs on EXT_LEDS
//   - led_pattern: maps an FSM state plus the two heartbeat counter taps
//                  onto the 3-bit LED vector
package pcie_status_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    WAIT_RST  = 2'd1,
    RUN       = 2'd2,
    FAULT     = 2'd3
  } state_e;

  localparam int LED_LOCK = 0;
  localparam int LED_RST  = 1;
  localparam int LED_HB   = 2;

  // The lock LED shows the fast blink tap while faulted so a lost lock is
  // visible on the board. The heartbeat LED follows the slow tap in every
  // state, which shows the clock is still running.
  function automatic logic [2:0] led_pattern(state_e st, logic fast_tap, logic slow_tap);
    logic [2:0] leds;
    leds           = 3'b000;
    leds[LED_HB]   = slow_tap;
    leds[LED_RST]  = (st == RUN);
    case (st)
      WAIT_LOCK: leds[LED_LOCK] = 1'b0;
      WAIT_RST,
      RUN:       leds[LED_LOCK] = 1'b1;
      FAULT:     leds[LED_LOCK] = fast_tap;
      default:   leds[LED_LOCK] = 1'b0;
    endcase
    return leds;
  endfunction

endpackage

// File: rtl/pcie_status_led_ctrl_if.sv
// pcie_status_if
//   Bundles the status nets consumed by the LED controller and the
//   indications it produces.
//   Inputs to the controller:
//     pcie_mmcm_locked, interconnect_aresetn, peripheral_aresetn (async)
//     clear_fault (single-cycle synchronous pulse)
//   Outputs from the controller:
//     EXT_LEDS[2:0], state_o[1:0], fault, lock_loss_cnt[LOSS_W-1:0]
//   Modports: master drives the status nets (board / bench side),
//             slave is the controller.
interface pcie_status_if #(
  parameter int LOSS_W = 4
);
  logic              pcie_mmcm_locked;
  logic              interconnect_aresetn;
  logic              peripheral_aresetn;
  logic              clear_fault;
  logic [2:0]        EXT_LEDS;
  logic [1:0]        state_o;
  logic              fault;
  logic [LOSS_W-1:0] lock_loss_cnt;

  modport master (
    output pcie_mmcm_locked, interconnect_aresetn, peripheral_aresetn, clear_fault,
    input  EXT_LEDS, state_o, fault, lock_loss_cnt
  );

  modport slave (
    input  pcie_mmcm_locked, interconnect_aresetn, peripheral_aresetn, clear_fault,
    output EXT_LEDS, state_o, fault, lock_loss_cnt
  );
endinterface

// File: rtl/pcie_status_led_ctrl_sync_2ff.sv
// sync_2ff
//   Two-flop resynchroniser for a single asynchronous level.
//   Ports: clk_i (destination clock), rst_i (sync active-high, clears both
//          flops), d_i (async input), q_o (synchronised output)
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Both stages clear to 0 so that a freshly reset design reads every
  // status net as "unlocked / still in reset".
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pcie_status_led_ctrl.sv
// pcie_status_led_ctrl
//   Watches the PCIe/PS status nets (MMCM lock plus the interconnect and
//   peripheral resets) and drives the three board LEDs: lock, resets
//   released and heartbeat. A lock loss while running latches a sticky
//   FAULT that software acknowledges with clear_fault, and each such loss
//   bumps a saturating counter.
//   Ports:
//     pcie_clk_125MHz : the only clock
//     sys_rst         : synchronous active-high reset, overrides all else
//     bus             : pcie_status_if slave (status nets in, LEDs/state/
//                       fault/lock_loss_cnt out)
module pcie_status_led_ctrl
  import pcie_status_pkg::*;
#(
  parameter int CNT_W              = 28,
  parameter int FAST_BIT           = 23,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int LOSS_W             = 4
) (
  input  logic                pcie_clk_125MHz,
  input  logic                sys_rst,
  pcie_status_if.slave        bus
);

  localparam int                STAB_W   = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(LOCK_STABLE_CYCLES);

  logic lk_s;
  logic icn_ok_s;
  logic per_ok_s;
  logic rst_ok_s;
  logic lock_stable;

  logic [STAB_W-1:0] stab_q;
  logic [CNT_W-1:0]  cnt_q;
  state_e            state_q, state_d;
  logic [LOSS_W-1:0] loss_q, loss_d;

  logic [2:0]        led_q;
  logic [1:0]        state_out_q;
  logic              fault_q;
  logic [LOSS_W-1:0] loss_out_q;

  sync_2ff u_sync_lock (
    .clk_i (pcie_clk_125MHz),
    .rst_i (sys_rst),
    .d_i   (bus.pcie_mmcm_locked),
    .q_o   (lk_s)
  );

  sync_2ff u_sync_icn (
    .clk_i (pcie_clk_125MHz),
    .rst_i (sys_rst),
    .d_i   (bus.interconnect_aresetn),
    .q_o   (icn_ok_s)
  );

  sync_2ff u_sync_per (
    .clk_i (pcie_clk_125MHz),
    .rst_i (sys_rst),
    .d_i   (bus.peripheral_aresetn),
    .q_o   (per_ok_s)
  );

  assign rst_ok_s    = icn_ok_s & per_ok_s;
  assign lock_stable = (stab_q == STAB_MAX);

  // Lock is only trusted after an unbroken run of synced-high cycles; any
  // low cycle restarts the run. The count parks at its maximum.
  always_ff @(posedge pcie_clk_125MHz) begin
    if (sys_rst) begin
      stab_q <= '0;
    end else if (!lk_s) begin
      stab_q <= '0;
    end else if (stab_q != STAB_MAX) begin
      stab_q <= stab_q + 1'b1;
    end
  end

  // Free-running heartbeat; it wraps naturally and keeps going in FAULT.
  always_ff @(posedge pcie_clk_125MHz) begin
    if (sys_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // FSM state and the lock-loss counter update on the same edge so the
  // counter tracks RUN->FAULT transitions exactly once each.
  always_ff @(posedge pcie_clk_125MHz) begin
    if (sys_rst) begin
      state_q <= WAIT_LOCK;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      loss_q  <= loss_d;
    end
  end

  // Next-state logic. Losing lock in RUN beats a reset drop so a combined
  // event is reported as a fault. Losing lock before RUN is part of normal
  // bring-up and is not a fault.
  always_comb begin
    state_d = state_q;
    loss_d  = loss_q;
    case (state_q)
      WAIT_LOCK: begin
        if (lock_stable) state_d = WAIT_RST;
      end
      WAIT_RST: begin
        if (!lk_s)                        state_d = WAIT_LOCK;
        else if (lock_stable && rst_ok_s) state_d = RUN;
      end
      RUN: begin
        if (!lk_s) begin
          state_d = FAULT;
          if (loss_q != {LOSS_W{1'b1}}) loss_d = loss_q + 1'b1;
        end else if (!rst_ok_s) begin
          state_d = WAIT_RST;
        end
      end
      FAULT: begin
        if (bus.clear_fault && lock_stable) state_d = WAIT_LOCK;
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Every external indication is registered off the current state, so it
  // trails the state register by one cycle.
  always_ff @(posedge pcie_clk_125MHz) begin
    if (sys_rst) begin
      led_q       <= 3'b000;
      state_out_q <= 2'd0;
      fault_q     <= 1'b0;
      loss_out_q  <= '0;
    end else begin
      led_q       <= led_pattern(state_q, cnt_q[FAST_BIT], cnt_q[CNT_W-1]);
      state_out_q <= state_q;
      fault_q     <= (state_q == FAULT);
      loss_out_q  <= loss_q;
    end
  end

  assign bus.EXT_LEDS      = led_q;
  assign bus.state_o       = state_out_q;
  assign bus.fault         = fault_q;
  assign bus.lock_loss_cnt = loss_out_q;

endmodule

// File: tb/tb_pcie_status_led_ctrl.sv
// tb_pcie_status_led_ctrl
//   Self-checking bench for pcie_status_led_ctrl with small parameters
//   (CNT_W=8, FAST_BIT=2, LOCK_STABLE_CYCLES=4, LOSS_W=2). A cycle-level
//   model derives the expected outputs from the behavioural rules and is
//   compared against the DUT every cycle; directed scenarios add literal
//   expectations at hand-computed cycles.
module tb_pcie_status_led_ctrl;

  localparam int CNT_W    = 8;
  localparam int FAST_BIT = 2;
  localparam int LSC      = 4;
  localparam int LOSS_W   = 2;
  localparam int LOSS_MAX = (1 << LOSS_W) - 1;

  logic clk;
  logic sysRst;

  int compared   = 0;
  int mismatched = 0;

  pcie_status_if #(.LOSS_W(LOSS_W)) bus ();

  pcie_status_led_ctrl #(
    .CNT_W              (CNT_W),
    .FAST_BIT           (FAST_BIT),
    .LOCK_STABLE_CYCLES (LSC),
    .LOSS_W             (LOSS_W)
  ) dut (
    .pcie_clk_125MHz (clk),
    .sys_rst         (sysRst),
    .bus             (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: integers describing the behaviour, not the RTL registers.
  bit  modelValid = 1'b0;
  int  mState;
  int  runLen;
  int  hb;
  int  loss;
  bit  lkD1, lkD2, icnD1, icnD2, perD1, perD2;
  int  expState, expFault, expLoss, expLeds;

  // Advance the model on each rising edge using the inputs held since the
  // previous falling edge. Expected outputs describe the state before the
  // edge, since every output is one register stage behind the FSM.
  always @(posedge clk) begin
    int  nxt;
    bit  lkS, rstOk, stable;
    if (sysRst) begin
      modelValid = 1'b1;
      mState = 0; runLen = 0; hb = 0; loss = 0;
      lkD1 = 0; lkD2 = 0; icnD1 = 0; icnD2 = 0; perD1 = 0; perD2 = 0;
      expState = 0; expFault = 0; expLoss = 0; expLeds = 0;
    end else if (modelValid) begin
      lkS    = lkD2;
      rstOk  = icnD2 && perD2;
      stable = (runLen >= LSC);
      expState = mState;
      expFault = (mState == 3) ? 1 : 0;
      expLoss  = loss;
      expLeds  = ((hb / (1 << (CNT_W - 1))) % 2) * 4
               + ((mState == 2) ? 2 : 0)
               + ((mState == 0) ? 0 : (mState == 3) ? (hb / (1 << FAST_BIT)) % 2 : 1);
      nxt = mState;
      case (mState)
        0: if (stable) nxt = 1;
        1: if (!lkS) nxt = 0; else if (stable && rstOk) nxt = 2;
        2: if (!lkS) nxt = 3; else if (!rstOk) nxt = 1;
        3: if (bus.clear_fault && stable) nxt = 0;
        default: nxt = 0;
      endcase
      if (mState == 2 && nxt == 3 && loss < LOSS_MAX) loss++;
      mState = nxt;
      runLen = lkS ? runLen + 1 : 0;
      hb     = (hb + 1) % (1 << CNT_W);
      lkD2 = lkD1;  lkD1 = bus.pcie_mmcm_locked;
      icnD2 = icnD1; icnD1 = bus.interconnect_aresetn;
      perD2 = perD1; perD1 = bus.peripheral_aresetn;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle once the model has seen a reset, the whole output bundle
  // must match the model.
  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("model.state_o",  int'(bus.state_o),       expState);
      checkOutput("model.fault",    int'(bus.fault),         expFault);
      checkOutput("model.lossCnt",  int'(bus.lock_loss_cnt), expLoss);
      checkOutput("model.EXT_LEDS", int'(bus.EXT_LEDS),      expLeds);
    end
  end

  // Drive all status nets at a falling edge, then hold for some cycles.
  task automatic applyStimulus(input bit locked, input bit icn, input bit per, input int cycles);
    bus.pcie_mmcm_locked     = locked;
    bus.interconnect_aresetn = icn;
    bus.peripheral_aresetn   = per;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic pulseClear();
    bus.clear_fault = 1'b1;
    @(negedge clk);
    bus.clear_fault = 1'b0;
  endtask

  initial begin
    sysRst                   = 1'b1;
    bus.pcie_mmcm_locked     = 1'b0;
    bus.interconnect_aresetn = 1'b0;
    bus.peripheral_aresetn   = 1'b0;
    bus.clear_fault          = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst.state_o",  int'(bus.state_o), 0);
    checkOutput("rst.EXT_LEDS", int'(bus.EXT_LEDS), 0);
    checkOutput("rst.fault",    int'(bus.fault), 0);
    checkOutput("rst.lossCnt",  int'(bus.lock_loss_cnt), 0);

    $display("[TB] bring-up to RUN");
    sysRst = 1'b0;
    applyStimulus(1, 1, 1, 8);
    checkOutput("bringup.waitRst", int'(bus.state_o), 1);
    @(negedge clk);
    checkOutput("bringup.run",     int'(bus.state_o), 2);
    checkOutput("bringup.leds10",  int'(bus.EXT_LEDS[1:0]), 3);

    $display("[TB] heartbeat");
    repeat (119) @(negedge clk);
    checkOutput("hb.low127",  int'(bus.EXT_LEDS[2]), 0);
    @(negedge clk);
    checkOutput("hb.high128", int'(bus.EXT_LEDS[2]), 1);
    repeat (200) @(negedge clk);

    $display("[TB] lock loss in RUN");
    applyStimulus(0, 1, 1, 4);
    checkOutput("loss1.state_o", int'(bus.state_o), 3);
    checkOutput("loss1.fault",   int'(bus.fault), 1);
    checkOutput("loss1.lossCnt", int'(bus.lock_loss_cnt), 1);
    repeat (12) @(negedge clk);

    $display("[TB] clear while unlocked is ignored");
    pulseClear();
    repeat (3) @(negedge clk);
    checkOutput("clrUnstable.state_o", int'(bus.state_o), 3);

    $display("[TB] clear after lock is stable");
    applyStimulus(1, 1, 1, 8);
    pulseClear();
    @(negedge clk);
    checkOutput("clr.state_o", int'(bus.state_o), 0);
    checkOutput("clr.fault",   int'(bus.fault), 0);
    repeat (6) @(negedge clk);
    checkOutput("clr.backToRun", int'(bus.state_o), 2);

    $display("[TB] simultaneous lock loss and reset");
    applyStimulus(0, 0, 1, 4);
    checkOutput("combo.state_o", int'(bus.state_o), 3);
    checkOutput("combo.lossCnt", int'(bus.lock_loss_cnt), 2);
    applyStimulus(1, 1, 1, 8);
    pulseClear();
    repeat (6) @(negedge clk);

    $display("[TB] loss counter saturation");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1, 1, 6);
      applyStimulus(1, 1, 1, 8);
      pulseClear();
      repeat (6) @(negedge clk);
    end
    checkOutput("sat.lossCnt", int'(bus.lock_loss_cnt), 3);
    checkOutput("sat.state_o", int'(bus.state_o), 2);

    $display("[TB] peripheral reset in RUN");
    applyStimulus(1, 1, 0, 4);
    checkOutput("perRst.state_o", int'(bus.state_o), 1);
    checkOutput("perRst.led1",    int'(bus.EXT_LEDS[1]), 0);
    checkOutput("perRst.fault",   int'(bus.fault), 0);
    applyStimulus(1, 1, 1, 4);
    checkOutput("perRel.state_o", int'(bus.state_o), 2);

    $display("[TB] sys_rst during FAULT");
    applyStimulus(0, 1, 1, 6);
    checkOutput("fault5.lossCnt", int'(bus.lock_loss_cnt), 3);
    checkOutput("fault5.state_o", int'(bus.state_o), 3);
    sysRst = 1'b1;
    @(negedge clk);
    checkOutput("midRst.state_o",  int'(bus.state_o), 0);
    checkOutput("midRst.fault",    int'(bus.fault), 0);
    checkOutput("midRst.lossCnt",  int'(bus.lock_loss_cnt), 0);
    checkOutput("midRst.EXT_LEDS", int'(bus.EXT_LEDS), 0);
    sysRst = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
